// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes (also used by the ALU control decoder),
// datapath width and the EX-stage ALU state encoding.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b1010;

    typedef enum logic {
        IDLE,
        MUL
    } alu_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// 32-iteration shift-add multiplier; returns the low WIDTH bits of the product,
// which are the same for signed and unsigned operands.
module shift_add_mul
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] acc;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] partial;
    logic             step;

    assign step    = run & ~flush;
    assign partial = multiplier[0] ? multiplicand : '0;
    // product already includes the current iteration's add, so it is final when done
    assign product = acc + partial;
    assign done    = step && (cnt == 5'd31);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multiplicand <= '0;
            multiplier   <= '0;
            acc          <= '0;
            cnt          <= '0;
        end else if (start) begin
            multiplicand <= op_a;
            multiplier   <= op_b;
            acc          <= '0;
            cnt          <= '0;
        end else if (step) begin
            acc          <= product;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            cnt          <= cnt + 5'd1;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// EX-stage ALU: single-cycle add/sub/and/or, multi-cycle mul, valid/ready
// handshake with a stall output while a multiply is in flight.
module multicycle_alu
    import alu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic             valid_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o,
    output logic             stall_o
);

    alu_state_t       state;
    alu_state_t       next_state;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_result;

    assign ready_o   = (state == IDLE);
    assign stall_o   = ~ready_o;
    assign accept    = valid_i & ready_o & ~flush_i;
    assign is_mul    = (ALUCtrl_i == ALU_MUL);
    assign mul_start = accept & is_mul;

    always_comb begin
        alu_result = '0;
        case (ALUCtrl_i)
            ALU_ADD: alu_result = data1_i + data2_i;
            ALU_SUB: alu_result = data1_i - data2_i;
            ALU_AND: alu_result = data1_i & data2_i;
            ALU_OR:  alu_result = data1_i | data2_i;
            default: alu_result = '0;
        endcase
    end

    shift_add_mul u_mul (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .start   (mul_start),
        .run     (state == MUL),
        .flush   (flush_i),
        .op_a    (data1_i),
        .op_b    (data2_i),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (mul_start) next_state = MUL;
            MUL:  if (flush_i || mul_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Result registers hold their value whenever no new result is produced
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            Zero_o  <= 1'b1;
        end else begin
            valid_o <= 1'b0;
            if (!flush_i) begin
                if (accept && !is_mul) begin
                    valid_o <= 1'b1;
                    data_o  <= alu_result;
                    Zero_o  <= (alu_result == '0);
                end else if (state == MUL && mul_done) begin
                    valid_o <= 1'b1;
                    data_o  <= mul_product;
                    Zero_o  <= (mul_product == '0);
                end
            end
        end
    end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Execution-stage ALU consuming the 4-bit ALU control code produced by the ALU control decoder. It executes add, sub, and, or in one registered cycle, and mul through a 32-iteration shift-add sequence. A valid/ready handshake lets the pipeline stall while a multiply is in flight. It replaces the purely combinational ALU in the EX stage.

## Interface
- WIDTH, 32, operand/result width; fixed at 32 in this design.
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- data1_i  in  32  operand A (rs).
- data2_i  in  32  operand B (rt or sign-extended immediate).
- ALUCtrl_i  in  4  operation code.
- valid_i  in  1  operands and code valid this cycle.
- flush_i  in  1  synchronous abort of the current operation.
- ready_o  out  1  block can accept; equals (state == IDLE).
- valid_o  out  1  data_o/Zero_o hold a new result; one-cycle pulse per result.
- data_o  out  32  registered result.
- Zero_o  out  1  registered (data_o == 0).
- stall_o  out  1  equals ~ready_o; drives the pipeline stall.

## Operation
- Codes: 0010 add, 0110 sub, 0000 and, 0001 or, 1010 mul. Any other code gives result 0.
- Accept condition: valid_i & ready_o & ~flush_i at a rising edge. When not accepted, valid_i is ignored and nothing is queued.
- Add and sub wrap modulo 2^32. There is no overflow flag.
- Mul returns the low 32 bits of the product, which are identical for signed and unsigned operands.
- States:
  - IDLE: ready_o=1.
    - Accepting a non-mul op writes data_o and Zero_o and sets valid_o=1; the block stays in IDLE.
    - Accepting mul latches multiplicand=data1_i, multiplier=data2_i, acc=0, cnt=0, and moves to MUL.
    - With no accept, valid_o=0.
  - MUL: ready_o=0, valid_o=0. Each edge:
    - If multiplier[0]=1, acc += multiplicand.
    - multiplicand <<= 1, multiplier >>= 1, cnt++.
    - On the edge where cnt==31: data_o takes the final acc, including that iteration's add. Zero_o updates, valid_o=1, and state returns to IDLE.
- flush_i has highest priority after reset:
  - In MUL, it moves state to IDLE and sets valid_o=0. data_o and Zero_o keep their old values.
  - In IDLE, it blocks acceptance and forces valid_o=0.
- Reset, at any time including mid-MUL: state=IDLE, ready_o=1, valid_o=0, data_o=0, Zero_o=1, acc/cnt/operands=0.
- When valid_o=0, data_o and Zero_o hold their last values.

## Timing
- Non-mul latency: accept at edge E0, result and valid_o visible after E0 (1 cycle). Back-to-back accepts every cycle are allowed.
- Mul latency: accept at E0, iterations at E1..E32, valid_o=1 and ready_o=1 after E32.
  - ready_o and stall_o are inactive and active respectively for exactly 32 cycles.
  - A new op can be accepted at E33.
- ready_o is a function of state only. There is no combinational path from valid_i to ready_o.
- Operands are sampled only at accept; changes to data*_i during MUL have no effect.

## Structure
- Package alu_pkg holds:
  - ALU_ADD/ALU_SUB/ALU_AND/ALU_OR/ALU_MUL code constants, shared with the ALU control decoder.
  - The state enum {IDLE, MUL}.
  - WIDTH=32.
- One sub-module, shift_add_mul. It takes start/flush, the operand regs, acc, and the 5-bit cnt, and outputs done plus product. The top level contains the FSM, the single-cycle datapath, and the output registers.

## Test plan
- Reset, then add 5+7 with valid_i for 1 cycle → next cycle valid_o=1, data_o=12, Zero_o=0. valid_o=0 the cycle after.
- Back-to-back sub 9-9, or 0xF0|0x0F, and 0xFF&0x0F, one per cycle → valid_o high 3 cycles: data_o 0 with Zero_o=1, then 0xFF, then 0x0F.
- mul 0xFFFFFFFF*3 → ready_o=0 for 32 cycles, then data_o=0xFFFFFFFD with valid_o=1 exactly 32 cycles after accept. valid_i held during MUL is not accepted.
- mul 0x10000*0x10000 → data_o=0, Zero_o=1 after 32 cycles. Undefined code 0x7 → data_o=0, 1 cycle.
- mul 6*7, flush_i at iteration 10 → ready_o=1 next cycle, no valid_o pulse, data_o unchanged. A following add 1+1 yields 2.
- mul 6*7, rst_n_i low asynchronously mid-MUL → outputs immediately at reset values. After release, mul 6*7 completes with data_o=42.
